// File: rtl/go_board_render.sv
// Go board renderer: draws the grid, stones and a blinking cursor for the current raster position.
// Fixed 3-cycle latency from timing inputs to pixel/sync outputs, no backpressure; board RAM read issued from stage 1.
module go_board_render #(
  parameter int BOARD_N      = 9,
  parameter int PITCH        = 80,
  parameter int ORIGIN_X     = 192,
  parameter int ORIGIN_Y     = 64,
  parameter int STONE_R      = 32,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                                 vclock_in,
  input  logic                                 reset_in,
  input  logic [10:0]                          hcount_in,
  input  logic [9:0]                           vcount_in,
  input  logic                                 hsync_in,
  input  logic                                 vsync_in,
  input  logic                                 blank_in,
  output logic [$clog2(BOARD_N*BOARD_N)-1:0]   brd_addr_out,
  input  logic [1:0]                           brd_data_in,
  input  logic [4:0]                           cursor_row_in,
  input  logic [4:0]                           cursor_col_in,
  input  logic                                 cursor_en_in,
  output logic                                 phsync_out,
  output logic                                 pvsync_out,
  output logic                                 pblank_out,
  output logic [11:0]                          pixel_out
);

  localparam int AW   = $clog2(BOARD_N*BOARD_N);
  localparam int DW   = $clog2(PITCH) + 1;
  localparam int MW   = DW - 1;
  localparam int SW   = 2*MW + 1;
  localparam int BW   = $clog2(BLINK_FRAMES + 1);
  localparam int HALF = PITCH / 2;
  // Biases keep the reload-constant divisions on non-negative operands.
  localparam int XB   = PITCH * (ORIGIN_X / PITCH + 1);
  localparam int YB   = PITCH * (ORIGIN_Y / PITCH + 1);
  localparam int X0S  = HALF - ORIGIN_X + XB;
  localparam int Y0S  = HALF - ORIGIN_Y + YB;

  localparam logic signed [11:0]   COL0 = 12'(X0S / PITCH - XB / PITCH);
  localparam logic signed [11:0]   ROW0 = 12'(Y0S / PITCH - YB / PITCH);
  localparam logic signed [DW-1:0] DX0  = DW'(X0S % PITCH - HALF);
  localparam logic signed [DW-1:0] DY0  = DW'(Y0S % PITCH - HALF);
  localparam logic signed [DW-1:0] DMAX = DW'(HALF - 1);
  localparam logic signed [DW-1:0] DMIN = DW'(-HALF);
  localparam logic signed [11:0]   NMAX = 12'(BOARD_N - 1);
  localparam logic [4:0]           N5   = 5'(BOARD_N);
  localparam logic [AW-1:0]        NA   = AW'(BOARD_N);

  logic [10:0]            hprev_q;
  logic [9:0]             vprev_q;
  logic signed [DW-1:0]   dx_q, dx_d, dy_q, dy_d;
  logic signed [11:0]     col_q, col_d, row_q, row_d;

  always_comb begin
    dx_d  = dx_q;
    col_d = col_q;
    if (hcount_in == 11'd0) begin
      dx_d  = DX0;
      col_d = COL0;
    end else if (hcount_in != hprev_q) begin
      if (dx_q == DMAX) begin
        dx_d  = DMIN;
        col_d = col_q + 12'sd1;
      end else begin
        dx_d  = dx_q + DW'(1);
      end
    end
  end

  always_comb begin
    dy_d  = dy_q;
    row_d = row_q;
    if (vcount_in == 10'd0) begin
      dy_d  = DY0;
      row_d = ROW0;
    end else if (vcount_in != vprev_q) begin
      if (dy_q == DMAX) begin
        dy_d  = DMIN;
        row_d = row_q + 12'sd1;
      end else begin
        dy_d  = dy_q + DW'(1);
      end
    end
  end

  // Trackers stay out of reset so they keep following the raster through a mid-frame reset.
  always_ff @(posedge vclock_in) begin
    hprev_q <= hcount_in;
    vprev_q <= vcount_in;
    dx_q    <= dx_d;
    col_q   <= col_d;
    dy_q    <= dy_d;
    row_q   <= row_d;
  end

  logic              vs_q, blink_q;
  logic [BW-1:0]     blink_cnt_q;

  always_ff @(posedge vclock_in or posedge reset_in) begin
    if (reset_in) begin
      vs_q        <= 1'b1;
      blink_cnt_q <= '0;
      blink_q     <= 1'b1;
    end else begin
      vs_q <= vsync_in;
      if (cursor_en_in && vs_q && !vsync_in) begin
        if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
          blink_cnt_q <= '0;
          blink_q     <= ~blink_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + BW'(1);
        end
      end
    end
  end

  logic           in_col, in_row, x_ext, y_ext, region_c, grid_c, cur_c;
  logic [MW-1:0]  adx_c, ady_c;
  logic [AW-1:0]  addr_c;

  always_comb begin
    in_col   = !col_d[11] && (col_d <= NMAX);
    in_row   = !row_d[11] && (row_d <= NMAX);
    x_ext    = in_col && !(col_d == 12'sd0 && dx_d[DW-1])
                      && !(col_d == NMAX && !dx_d[DW-1] && dx_d != '0);
    y_ext    = in_row && !(row_d == 12'sd0 && dy_d[DW-1])
                      && !(row_d == NMAX && !dy_d[DW-1] && dy_d != '0);
    region_c = in_col && in_row;
    grid_c   = (dx_d == '0 || dy_d == '0) && x_ext && y_ext;
    adx_c    = dx_d[DW-1] ? MW'(-dx_d) : MW'(dx_d);
    ady_c    = dy_d[DW-1] ? MW'(-dy_d) : MW'(dy_d);
    addr_c   = region_c ? (AW'(row_d) * NA + AW'(col_d)) : '0;
    cur_c    = cursor_en_in && blink_q && region_c
               && (cursor_row_in < N5) && (cursor_col_in < N5)
               && (cursor_row_in == row_d[4:0]) && (cursor_col_in == col_d[4:0]);
  end

  logic [AW-1:0]  addr_q;
  logic [MW-1:0]  adx1_q, ady1_q;
  logic           region1_q, grid1_q, cur1_q;
  logic           region2_q, grid2_q, cur2_q, stone2_q;
  logic [2:0]     tim1_q, tim2_q, tim3_q;
  logic [11:0]    pix_q, pix_d;
  logic [SW-1:0]  sq_c;
  logic [MW-1:0]  mx_c;
  logic           ring_c;

  always_comb begin
    sq_c   = SW'(adx1_q) * SW'(adx1_q) + SW'(ady1_q) * SW'(ady1_q);
    mx_c   = (adx1_q > ady1_q) ? adx1_q : ady1_q;
    ring_c = (mx_c >= MW'(STONE_R + 2)) && (mx_c <= MW'(STONE_R + 4));
  end

  // RAM data for the stage-2 pixel arrives now, one cycle after brd_addr_out.
  always_comb begin
    pix_d = 12'hFF0;
    if (tim2_q[0] || !region2_q)                pix_d = 12'h000;
    else if (cur2_q)                            pix_d = 12'hF00;
    else if (stone2_q && brd_data_in == 2'b01)  pix_d = 12'h000;
    else if (stone2_q && brd_data_in == 2'b10)  pix_d = 12'hFFF;
    else if (grid2_q)                           pix_d = 12'h000;
  end

  always_ff @(posedge vclock_in or posedge reset_in) begin
    if (reset_in) begin
      addr_q    <= '0;
      adx1_q    <= '0;
      ady1_q    <= '0;
      region1_q <= 1'b0;
      grid1_q   <= 1'b0;
      cur1_q    <= 1'b0;
      tim1_q    <= 3'b111;
      region2_q <= 1'b0;
      grid2_q   <= 1'b0;
      cur2_q    <= 1'b0;
      stone2_q  <= 1'b0;
      tim2_q    <= 3'b111;
      pix_q     <= 12'h000;
      tim3_q    <= 3'b111;
    end else begin
      addr_q    <= addr_c;
      adx1_q    <= adx_c;
      ady1_q    <= ady_c;
      region1_q <= region_c;
      grid1_q   <= grid_c;
      cur1_q    <= cur_c;
      tim1_q    <= {hsync_in, vsync_in, blank_in};
      region2_q <= region1_q;
      grid2_q   <= grid1_q;
      cur2_q    <= cur1_q && ring_c;
      stone2_q  <= (sq_c <= SW'(STONE_R * STONE_R));
      tim2_q    <= tim1_q;
      pix_q     <= pix_d;
      tim3_q    <= tim2_q;
    end
  end

  assign brd_addr_out = addr_q;
  assign pixel_out    = pix_q;
  assign phsync_out   = tim3_q[2];
  assign pvsync_out   = tim3_q[1];
  assign pblank_out   = tim3_q[0];

endmodule
